// File: rtl/gtx_dword_assembler.sv
// gtx_dword_assembler
// Pairs 16-bit words from the elastic buffer into 32-bit dwords. Each dword
// is classified as data or as a SATA primitive. ALIGNp is dropped. CONTp
// repetition is resolved into repeats of the last primitive. Code and
// framing errors are flagged. All outputs are registered.
module gtx_dword_assembler #(
  parameter int PRIM_NUM      = 12,
  parameter int CONT_HOLD_MAX = 4095
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                isaligned_in,
  input  logic [15:0]         data_in,
  input  logic [1:0]          charisk_in,
  input  logic [1:0]          notintable_in,
  input  logic [1:0]          disperror_in,
  input  logic                lword_strobe,
  output logic [31:0]         dword_out,
  output logic                dword_valid,
  output logic                is_data,
  output logic [PRIM_NUM-1:0] prim_out,
  output logic                cont_active,
  output logic                err_code,
  output logic                err_frame,
  output logic                err_cont_timeout
);

  localparam logic [31:0] ALIGN_DW = 32'h7B4A4ABC;
  localparam logic [31:0] CONT_DW  = 32'h9999AA7C;
  localparam logic [11:0] HOLD_MAX = 12'(CONT_HOLD_MAX);

  typedef enum logic [0:0] {
    ST_LO = 1'b0,
    ST_HI = 1'b1
  } state_t;

  // One-hot lookup of the primitive table; zero when the dword is not listed.
  function automatic logic [PRIM_NUM-1:0] prim_lookup(input logic [31:0] dw);
    logic [PRIM_NUM-1:0] hit;
    hit = {PRIM_NUM{1'b0}};
    case (dw)
      32'hB5B5957C: hit[0]  = 1'b1;  // SYNC
      32'h5757B57C: hit[1]  = 1'b1;  // X_RDY
      32'h4A4A957C: hit[2]  = 1'b1;  // R_RDY
      32'h3737B57C: hit[3]  = 1'b1;  // SOF
      32'hD5D5B57C: hit[4]  = 1'b1;  // EOF
      32'h5555B57C: hit[5]  = 1'b1;  // R_IP
      32'h3535B57C: hit[6]  = 1'b1;  // R_OK
      32'h5656B57C: hit[7]  = 1'b1;  // R_ERR
      32'hD5D5AA7C: hit[8]  = 1'b1;  // HOLD
      32'h9595AA7C: hit[9]  = 1'b1;  // HOLDA
      32'h5858B57C: hit[10] = 1'b1;  // WTRM
      32'h3636B57C: hit[11] = 1'b1;  // DMAT
      default:      hit     = {PRIM_NUM{1'b0}};
    endcase
    return hit;
  endfunction

  // OR of the per-byte 8b10b error flags of one word.
  function automatic logic word_code_err(input logic [1:0] nit, input logic [1:0] dis);
    return (|nit) | (|dis);
  endfunction

  state_t              state_r, state_s;
  logic [15:0]         lo_word_r, lo_word_s;
  logic [1:0]          lo_k_r, lo_k_s;
  logic                lo_err_r, lo_err_s;
  logic [PRIM_NUM-1:0] last_prim_r, last_prim_s;
  logic [31:0]         last_dword_r, last_dword_s;
  logic                cont_r, cont_s;
  logic [11:0]         junk_cnt_r, junk_cnt_s;
  logic [31:0]         dword_r, dword_s;
  logic                valid_r, valid_s;
  logic                is_data_r, is_data_s;
  logic [PRIM_NUM-1:0] prim_r, prim_s;
  logic                err_code_r, err_code_s;
  logic                err_frame_r, err_frame_s;
  logic                err_to_r, err_to_s;

  logic [31:0]         asm_dword_s;
  logic [3:0]          asm_k_s;
  logic                asm_err_s;
  logic [PRIM_NUM-1:0] asm_hit_s;

  // Candidate dword formed from the latched low word and the incoming word.
  always_comb begin
    asm_dword_s = {data_in, lo_word_r};
    asm_k_s     = {charisk_in, lo_k_r};
    asm_err_s   = lo_err_r | word_code_err(notintable_in, disperror_in);
    asm_hit_s   = prim_lookup(asm_dword_s);
  end

  // Pairing FSM, classification and CONT tracking; pulses default to zero.
  always_comb begin
    state_s      = state_r;
    lo_word_s    = lo_word_r;
    lo_k_s       = lo_k_r;
    lo_err_s     = lo_err_r;
    last_prim_s  = last_prim_r;
    last_dword_s = last_dword_r;
    cont_s       = cont_r;
    junk_cnt_s   = junk_cnt_r;
    dword_s      = 32'h0000_0000;
    valid_s      = 1'b0;
    is_data_s    = 1'b0;
    prim_s       = {PRIM_NUM{1'b0}};
    err_code_s   = 1'b0;
    err_frame_s  = 1'b0;
    err_to_s     = 1'b0;

    if (!isaligned_in) begin
      // Loss of alignment wipes all pairing and CONT context.
      state_s     = ST_LO;
      lo_word_s   = 16'h0000;
      lo_k_s      = 2'b00;
      lo_err_s    = 1'b0;
      last_prim_s = {PRIM_NUM{1'b0}};
      cont_s      = 1'b0;
      junk_cnt_s  = 12'd0;
    end else begin
      case (state_r)
        ST_LO: begin
          if (lword_strobe) begin
            // Orphan high word: dropped, flagged without a dword slot.
            err_frame_s = 1'b1;
          end else begin
            lo_word_s = data_in;
            lo_k_s    = charisk_in;
            lo_err_s  = word_code_err(notintable_in, disperror_in);
            state_s   = ST_HI;
          end
        end
        ST_HI: begin
          if (!lword_strobe) begin
            // Repeated low word: keep the newest one and flag it.
            lo_word_s   = data_in;
            lo_k_s      = charisk_in;
            lo_err_s    = word_code_err(notintable_in, disperror_in);
            err_frame_s = 1'b1;
          end else begin
            state_s = ST_LO;
            if (asm_err_s || ((asm_k_s != 4'b0000) && (asm_k_s != 4'b0001))) begin
              // Coding errors or illegal K layout: never matched as a primitive.
              valid_s     = 1'b1;
              dword_s     = asm_dword_s;
              err_code_s  = asm_err_s;
              err_frame_s = 1'b1;
            end else if (asm_k_s == 4'b0000) begin
              valid_s = 1'b1;
              if (cont_r) begin
                // Junk after CONTp is replaced by the repeated primitive.
                dword_s = last_dword_r;
                prim_s  = last_prim_r;
                if (junk_cnt_r == HOLD_MAX) begin
                  err_to_s   = 1'b1;
                  cont_s     = 1'b0;
                  junk_cnt_s = 12'd0;
                end else if (junk_cnt_r != 12'hFFF) begin
                  junk_cnt_s = junk_cnt_r + 12'd1;
                end else begin
                  junk_cnt_s = junk_cnt_r;
                end
              end else begin
                dword_s   = asm_dword_s;
                is_data_s = 1'b1;
              end
            end else if (asm_dword_s == ALIGN_DW) begin
              // ALIGNp is silently consumed.
              valid_s = 1'b0;
            end else if (asm_dword_s == CONT_DW) begin
              valid_s = 1'b1;
              if (last_prim_r != {PRIM_NUM{1'b0}}) begin
                cont_s  = 1'b1;
                dword_s = last_dword_r;
                prim_s  = last_prim_r;
              end else begin
                // CONTp with nothing to repeat.
                dword_s     = asm_dword_s;
                err_frame_s = 1'b1;
              end
            end else if (asm_hit_s != {PRIM_NUM{1'b0}}) begin
              valid_s      = 1'b1;
              dword_s      = asm_dword_s;
              prim_s       = asm_hit_s;
              last_prim_s  = asm_hit_s;
              last_dword_s = asm_dword_s;
              cont_s       = 1'b0;
              junk_cnt_s   = 12'd0;
            end else begin
              // K-dword that is not in the primitive table.
              valid_s     = 1'b1;
              dword_s     = asm_dword_s;
              err_frame_s = 1'b1;
            end
          end
        end
        default: begin
          state_s = ST_LO;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_LO;
      lo_word_r    <= 16'h0000;
      lo_k_r       <= 2'b00;
      lo_err_r     <= 1'b0;
      last_prim_r  <= {PRIM_NUM{1'b0}};
      last_dword_r <= 32'h0000_0000;
      cont_r       <= 1'b0;
      junk_cnt_r   <= 12'd0;
      dword_r      <= 32'h0000_0000;
      valid_r      <= 1'b0;
      is_data_r    <= 1'b0;
      prim_r       <= {PRIM_NUM{1'b0}};
      err_code_r   <= 1'b0;
      err_frame_r  <= 1'b0;
      err_to_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      lo_word_r    <= lo_word_s;
      lo_k_r       <= lo_k_s;
      lo_err_r     <= lo_err_s;
      last_prim_r  <= last_prim_s;
      last_dword_r <= last_dword_s;
      cont_r       <= cont_s;
      junk_cnt_r   <= junk_cnt_s;
      dword_r      <= dword_s;
      valid_r      <= valid_s;
      is_data_r    <= is_data_s;
      prim_r       <= prim_s;
      err_code_r   <= err_code_s;
      err_frame_r  <= err_frame_s;
      err_to_r     <= err_to_s;
    end
  end

  assign dword_out        = dword_r;
  assign dword_valid      = valid_r;
  assign is_data          = is_data_r;
  assign prim_out         = prim_r;
  assign cont_active      = cont_r;
  assign err_code         = err_code_r;
  assign err_frame        = err_frame_r;
  assign err_cont_timeout = err_to_r;

endmodule

// File: tb/tb_gtx_dword_assembler.sv
// Directed testbench for gtx_dword_assembler (CONT hold limit reduced to 3).
module tb_gtx_dword_assembler;

  logic        clk;
  logic        rst;
  logic        isaligned_in;
  logic [15:0] data_in;
  logic [1:0]  charisk_in;
  logic [1:0]  notintable_in;
  logic [1:0]  disperror_in;
  logic        lword_strobe;
  logic [31:0] dword_out;
  logic        dword_valid;
  logic        is_data;
  logic [11:0] prim_out;
  logic        cont_active;
  logic        err_code;
  logic        err_frame;
  logic        err_cont_timeout;

  int checks;
  int fails;

  // Observed vector: valid, dword, is_data, prim, cont, err_code, err_frame, err_to.
  logic [49:0] obs;
  logic [49:0] exp_v;
  assign obs = {dword_valid, dword_out, is_data, prim_out, cont_active,
                err_code, err_frame, err_cont_timeout};

  gtx_dword_assembler #(.PRIM_NUM(12), .CONT_HOLD_MAX(3)) dut (
    .clk             (clk),
    .rst             (rst),
    .isaligned_in    (isaligned_in),
    .data_in         (data_in),
    .charisk_in      (charisk_in),
    .notintable_in   (notintable_in),
    .disperror_in    (disperror_in),
    .lword_strobe    (lword_strobe),
    .dword_out       (dword_out),
    .dword_valid     (dword_valid),
    .is_data         (is_data),
    .prim_out        (prim_out),
    .cont_active     (cont_active),
    .err_code        (err_code),
    .err_frame       (err_frame),
    .err_cont_timeout(err_cont_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word for one cycle; returns at the next falling edge.
  task automatic drive(input logic [15:0] w, input logic [1:0] k,
                       input logic [1:0] ni, input logic s);
    data_in       = w;
    charisk_in    = k;
    notintable_in = ni;
    disperror_in  = 2'b00;
    lword_strobe  = s;
    @(negedge clk);
  endtask

  // Clean low word followed by clean high word.
  task automatic send_dw(input logic [15:0] lo, input logic [1:0] lok,
                         input logic [15:0] hi, input logic [1:0] hik);
    drive(lo, lok, 2'b00, 1'b0);
    drive(hi, hik, 2'b00, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    isaligned_in = 1'b0;
    repeat (3) @(negedge clk);
    exp_v = 50'd0;
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL reset_state: got %h expected %h", obs, exp_v);
      fails++;
    end
    rst = 1'b1;
    isaligned_in = 1'b1;
  endtask

  task automatic test_align;
    drive(16'h4ABC, 2'b01, 2'b00, 1'b0);
    exp_v = 50'd0;
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL align_lo: got %h expected %h", obs, exp_v);
      fails++;
    end
    drive(16'h7B4A, 2'b00, 2'b00, 1'b1);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL align_drop: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_sync;
    drive(16'h957C, 2'b01, 2'b00, 1'b0);
    checks++;
    if (dword_valid !== 1'b0) begin
      $display("FAIL sync_lo_valid: got %b expected 0", dword_valid);
      fails++;
    end
    drive(16'hB5B5, 2'b00, 2'b00, 1'b1);
    exp_v = {1'b1, 32'hB5B5957C, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL sync: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_cont_suppression;
    send_dw(16'hB57C, 2'b01, 16'h5757, 2'b00);
    exp_v = {1'b1, 32'h5757B57C, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_xrdy: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hAA7C, 2'b01, 16'h9999, 2'b00);
    exp_v = {1'b1, 32'h5757B57C, 1'b0, 12'h002, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_contp: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h5678, 2'b00, 16'h1234, 2'b00);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_junk1: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h4ABC, 2'b01, 16'h7B4A, 2'b00);
    exp_v = {1'b0, 32'h0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_align: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hDEF0, 2'b00, 16'h9ABC, 2'b00);
    exp_v = {1'b1, 32'h5757B57C, 1'b0, 12'h002, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_junk2: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h957C, 2'b01, 16'h4A4A, 2'b00);
    exp_v = {1'b1, 32'h4A4A957C, 1'b0, 12'h004, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_rrdy: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_data;
    send_dw(16'h5678, 2'b00, 16'h1234, 2'b00);
    exp_v = {1'b1, 32'h12345678, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL data: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_errors;
    drive(16'h5678, 2'b00, 2'b01, 1'b0);
    drive(16'h1234, 2'b00, 2'b00, 1'b1);
    exp_v = {1'b1, 32'h12345678, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_code: got %h expected %h", obs, exp_v);
      fails++;
    end
    drive(16'h0000, 2'b00, 2'b00, 1'b1);
    exp_v = {1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_orphan: got %h expected %h", obs, exp_v);
      fails++;
    end
    drive(16'hAAAA, 2'b00, 2'b00, 1'b0);
    drive(16'h5678, 2'b00, 2'b00, 1'b0);
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_repeat_lo: got %h expected %h", obs, exp_v);
      fails++;
    end
    drive(16'h1234, 2'b00, 2'b00, 1'b1);
    exp_v = {1'b1, 32'h12345678, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_repeat_dw: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h5678, 2'b00, 16'h1234, 2'b01);
    exp_v = {1'b1, 32'h12345678, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_k0100: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h007C, 2'b01, 16'h1111, 2'b00);
    exp_v = {1'b1, 32'h1111007C, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL err_not_in_table: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_realign;
    drive(16'h957C, 2'b01, 2'b00, 1'b0);
    isaligned_in = 1'b0;
    drive(16'hB5B5, 2'b00, 2'b00, 1'b1);
    isaligned_in = 1'b1;
    exp_v = 50'd0;
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL realign_discard: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hAA7C, 2'b01, 16'h9999, 2'b00);
    exp_v = {1'b1, 32'h9999AA7C, 1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL cont_no_last: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_timeout;
    send_dw(16'hAA7C, 2'b01, 16'hD5D5, 2'b00);
    exp_v = {1'b1, 32'hD5D5AA7C, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL to_hold: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hAA7C, 2'b01, 16'h9999, 2'b00);
    exp_v = {1'b1, 32'hD5D5AA7C, 1'b0, 12'h100, 1'b1, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL to_cont: got %h expected %h", obs, exp_v);
      fails++;
    end
    for (int i = 0; i < 3; i++) begin
      send_dw(16'h1111, 2'b00, 16'h2222, 2'b00);
      checks++;
      if (obs !== exp_v) begin
        $display("FAIL to_junk%0d: got %h expected %h", i, obs, exp_v);
        fails++;
      end
    end
    send_dw(16'h3333, 2'b00, 16'h4444, 2'b00);
    exp_v = {1'b1, 32'hD5D5AA7C, 1'b0, 12'h100, 1'b0, 1'b0, 1'b0, 1'b1};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL to_expire: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'h5555, 2'b00, 16'h6666, 2'b00);
    exp_v = {1'b1, 32'h66665555, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL to_after: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    send_dw(16'hB57C, 2'b01, 16'h3737, 2'b00);
    exp_v = {1'b1, 32'h3737B57C, 1'b0, 12'h008, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL b2b_sof: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hB57C, 2'b01, 16'hD5D5, 2'b00);
    exp_v = {1'b1, 32'hD5D5B57C, 1'b0, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL b2b_eof: got %h expected %h", obs, exp_v);
      fails++;
    end
    send_dw(16'hB57C, 2'b01, 16'h3636, 2'b00);
    exp_v = {1'b1, 32'h3636B57C, 1'b0, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL b2b_dmat: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  task automatic test_async_reset;
    send_dw(16'hAA7C, 2'b01, 16'h9999, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    exp_v = 50'd0;
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL async_reset: got %h expected %h", obs, exp_v);
      fails++;
    end
    @(negedge clk);
    rst = 1'b1;
    send_dw(16'h957C, 2'b01, 16'hB5B5, 2'b00);
    exp_v = {1'b1, 32'hB5B5957C, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (obs !== exp_v) begin
      $display("FAIL post_reset_sync: got %h expected %h", obs, exp_v);
      fails++;
    end
  endtask

  initial begin
    checks        = 0;
    fails         = 0;
    rst           = 1'b0;
    isaligned_in  = 1'b0;
    data_in       = 16'h0000;
    charisk_in    = 2'b00;
    notintable_in = 2'b00;
    disperror_in  = 2'b00;
    lword_strobe  = 1'b0;
    test_reset();
    test_align();
    test_sync();
    test_cont_suppression();
    test_data();
    test_errors();
    test_realign();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/gtx_dword_assembler.md
Name: gtx_dword_assembler

Overview:
- Sits in the rclk domain directly downstream of the elastic buffer and consumes its 16-bit words plus the last-word strobe.
- Pairs the words into 32-bit dwords and classifies each dword as data or as one of 12 SATA primitives.
- Drops ALIGNp, resolves CONTp repetition and flags code/framing errors.
- Feeds the link-layer receive FSM with one qualified dword per primitive slot.

Parameters:
- PRIM_NUM, 12, width of the one-hot primitive vector (fixed primitive table below).
- CONT_HOLD_MAX, 4095, maximum junk dwords accepted after CONTp before a cont_timeout error; 12-bit counter.

Ports:
- clk  input  1  receive word clock (same clock as the elastic buffer read side).
- rst  input  1  asynchronous, active-low reset.
- isaligned_in  input  1  comma alignment status from the elastic buffer.
- data_in  input  16  received word; the first word of a dword carries bytes 1:0.
- charisk_in  input  2  K-character flags per byte.
- notintable_in  input  2  8b10b not-in-table flags.
- disperror_in  input  2  disparity error flags.
- lword_strobe  input  1  high when the current word is the last (high) word of a dword.
- dword_out  output  32  assembled dword, {hi_word, lo_word}.
- dword_valid  output  1  one-cycle qualifier for dword_out, is_data and prim_out.
- is_data  output  1  the dword is a non-primitive data dword.
- prim_out  output  12  one-hot primitive; bit order SYNC, X_RDY, R_RDY, SOF, EOF, R_IP, R_OK, R_ERR, HOLD, HOLDA, WTRM, DMAT (bit0..bit11).
- cont_active  output  1  CONTp suppression is in effect.
- err_code  output  1  a notintable or disperror flag was seen in the dword.
- err_frame  output  1  charisk pattern is not 0000/0001, or the K-dword is not in the table.
- err_cont_timeout  output  1  the CONT_HOLD_MAX junk count was exceeded.

Behaviour:
- Reset, and whenever isaligned_in=0:
  - All outputs are 0.
  - The pairing FSM returns to LO; cont_active, last_prim and the junk counter are cleared.
  - Reset asserts asynchronously and is released synchronously through the internal flops.
- Pairing FSM:
  - LO: a word with lword_strobe=0 is latched as lo_word, with its flags; go to HI.
  - LO with lword_strobe=1 (orphan high word): discard it, pulse err_frame with dword_valid=0, stay in LO.
  - HI with lword_strobe=1: assemble the dword, evaluate it the same cycle, go to LO.
  - HI with lword_strobe=0 (repeated low word): replace lo_word, pulse err_frame, stay in HI.
- Latency: outputs are registered and appear one clk after the high word is presented. The minimum spacing between dword_valid pulses is 2 cycles.
- Classification uses the combined charisk K = {hi_k, lo_k}:
  - K=0000: data dword.
  - K=0001: look up the primitive table.
  - Any other K: err_frame=1, dword_valid=1, is_data=0, prim_out=0.
- Primitive table (hex, byte3..byte0): ALIGN 7B4A4ABC, CONT 9999AA7C, SYNC B5B5957C, X_RDY 5757B57C, R_RDY 4A4A957C, SOF 3737B57C, EOF D5D5B57C, R_IP 5555B57C, R_OK 3535B57C, R_ERR 5656B57C, HOLD D5D5AA7C, HOLDA 9595AA7C, WTRM 5858B57C, DMAT 3636B57C.
- A K=0001 dword not in the table gives err_frame=1 and prim_out=0; last_prim is unchanged.
- ALIGN: never produces dword_valid. It does not change cont_active or last_prim, and does not advance the junk counter.
- Table primitive other than CONT/ALIGN:
  - dword_valid=1, with the matching prim_out bit.
  - last_prim and last_dword are updated; cont_active is cleared and the junk counter set to 0.
- CONT with last_prim non-zero: set cont_active. Emit dword_valid with dword_out=last_dword and prim_out=last_prim.
- CONT with last_prim zero: set err_frame; no primitive is output and cont_active is unchanged.
- Data dword while cont_active=1 (junk):
  - Emit dword_valid=1 with dword_out=last_dword, prim_out=last_prim, is_data=0.
  - Increment the junk counter, saturating.
  - When the counter reaches CONT_HOLD_MAX+1: pulse err_cont_timeout and clear cont_active. That dword is still emitted as the repeated primitive.
- Data dword while cont_active=0: dword_valid=1, is_data=1, prim_out=0, dword_out is the raw dword.
- err_code:
  - Equals the OR of all four notintable/disperror bits of the dword, and is reported alongside that dword's classification.
  - An errored dword is never matched as a primitive: it is treated as K-pattern invalid and raises err_frame too.
- Simultaneous events: isaligned_in falling in the same cycle as a high word discards that dword.
- Error outputs are single-cycle pulses aligned with the dword_valid slot. The orphan/repeated-word err_frame pulses come with dword_valid=0.

Test Plan:
- Reset then alignment: hold rst=0, then release with isaligned_in=1. Feed 4ABC/K=01 followed by 7B4A with lword_strobe=0,1 → no dword_valid, all outputs 0.
- SYNC: feed 957C (K01, strobe 0) then B5B5 (strobe 1) → next cycle dword_valid=1, dword_out=B5B5957C, prim_out=12'h001, is_data=0.
- CONT suppression: send X_RDY, CONT, data 12345678, ALIGN, data 9ABCDEF0, then R_RDY.
  - X_RDY, CONT and both data dwords each produce prim_out=12'h002 with dword_out=5757B57C; cont_active=1 from the CONT dword.
  - The ALIGN produces no output.
  - R_RDY produces prim_out=12'h004 with cont_active=0.
- Data path: feed words 5678 then 1234 with K=00 → dword_out=12345678, is_data=1, prim_out=0.
- Errors:
  - A low word with notintable=01 gives err_code=1 and err_frame=1 in the same dword slot.
  - Two consecutive strobe=1 words give an err_frame pulse with dword_valid=0 for the orphan.
  - A dword with K=0100 gives err_frame=1 with dword_valid=1.
- Timeout (CONT_HOLD_MAX=3): send HOLD, CONT, then 4 data dwords. The 4th data dword gives err_cont_timeout=1 and cont_active drops; the 5th data dword has is_data=1.
